// File: rtl/imm_pkg.sv
// Shared definitions for the RISC-V immediate generator: format codes and
// the opcode/funct3 values the decoder recognises.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    localparam logic [5:0] SHIFT_HI_LOGIC = 6'b000000;
    localparam logic [5:0] SHIFT_HI_ARITH = 6'b010000;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational RISC-V immediate decoder: extracts and sign-extends the
// immediate of one instruction word and classifies its format.
module imm_gen_core
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [5:0]  shift_hi;
    logic        shamt_b5;
    logic        shamt_ok;
    logic [31:0] raw;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign shift_hi = inst[31:26];
    assign shamt_b5 = (XLEN == 64) ? inst[25] : 1'b0;

    // Bit 25 is the sixth shamt bit on RV64 but must be clear on RV32
    always_comb begin
        if (funct3 == F3_SLL) begin
            shamt_ok = (shift_hi == SHIFT_HI_LOGIC);
        end else begin
            shamt_ok = (shift_hi == SHIFT_HI_LOGIC) || (shift_hi == SHIFT_HI_ARITH);
        end
        if (XLEN == 32 && inst[25]) begin
            shamt_ok = 1'b0;
        end
    end

    always_comb begin
        raw     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                fmt = FMT_I;
                raw = {{20{inst[31]}}, inst[31:20]};
            end
            OP_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SRX) begin
                    fmt = FMT_SHAMT;
                    if (shamt_ok) begin
                        raw = {26'b0, shamt_b5, inst[24:20]};
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    fmt = FMT_I;
                    raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                raw = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // raw is already a 32-bit signed value; widening by cast sign-extends to XLEN
    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a small decoded-result FIFO, ready/valid
// handshakes on both sides and a saturating illegal-instruction counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      illegal_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             accept;
    logic             pop;

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;

    imm_gen_core #(
        .XLEN(XLEN)
    ) u_core (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // flush wins over both handshakes, so neither side completes that cycle
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (accept && !pop) begin
            count_nxt = count + (PTR_W+1)'(1);
        end else if (pop && !accept) begin
            count_nxt = count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt < (PTR_W+1)'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (accept && dec_illegal && illegal_cnt != '1) begin
                illegal_cnt <= illegal_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
        end
    end

    assign head        = mem[rd_ptr];
    assign out_imm     = out_valid ? head.imm     : '0;
    assign out_fmt     = out_valid ? head.fmt     : FMT_NONE;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
    assign out_tag     = out_valid ? head.tag     : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared inputs,
// checked every cycle against a queue-based reference model plus literals.
module tb_imm_gen_pipe;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_inst = '0;
    logic [TAG_W-1:0] in_tag = '0;

    logic             r32, v32, ill32, r64, v64, ill64;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [2:0]       fmt32, fmt64;
    logic [TAG_W-1:0] tag32, tag64;
    logic [15:0]      cnt32, cnt64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32),
        .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64),
        .illegal_cnt(cnt64)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference decode using signed arithmetic on the instruction fields
    function automatic void model_dec(input logic [31:0] i, input int xlen,
                                      output logic [63:0] imm, output logic [2:0] fmt,
                                      output logic ill);
        longint   v;
        logic [5:0] hi;
        bit       ok;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        hi  = i[31:26];
        case (i[6:0])
            7'h03, 7'h67: begin
                fmt = 3'd1;
                v = longint'(i[30:20]);
                if (i[31]) v -= 2048;
            end
            7'h13: begin
                if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                    fmt = 3'd2;
                    ok = (i[14:12] == 3'd1) ? (hi == 6'd0) : (hi == 6'd0 || hi == 6'd16);
                    if (xlen == 32 && i[25]) ok = 1'b0;
                    if (!ok) ill = 1'b1;
                    else v = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
                end else begin
                    fmt = 3'd1;
                    v = longint'(i[30:20]);
                    if (i[31]) v -= 2048;
                end
            end
            7'h23: begin
                fmt = 3'd3;
                v = longint'(i[30:25]) * 32 + longint'(i[11:7]);
                if (i[31]) v -= 2048;
            end
            7'h63: begin
                fmt = 3'd4;
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (i[31]) v -= 4096;
            end
            7'h37, 7'h17: begin
                fmt = 3'd5;
                v = longint'(i[30:12]) * 4096;
                if (i[31]) v -= (64'sd1 << 31);
            end
            7'h6F: begin
                fmt = 3'd6;
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (i[31]) v -= (64'sd1 << 20);
            end
            default: ill = 1'b1;
        endcase
        imm = 64'(v);
        if (xlen == 32) imm[63:32] = '0;
    endfunction

    logic [TAG_W+31:0] q[$];
    bit                m_ready = 1'b0;
    int                m_cnt32 = 0;
    int                m_cnt64 = 0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [63:0] d_imm;
        logic [2:0]  d_fmt;
        logic        d_ill;
        bit          acc, pp;
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0;
            m_cnt32 = 0;
            m_cnt64 = 0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && m_ready;
                pp  = (q.size() > 0) && out_ready;
                if (pp) void'(q.pop_front());
                if (acc) begin
                    q.push_back({in_tag, in_inst});
                    model_dec(in_inst, 32, d_imm, d_fmt, d_ill);
                    if (d_ill && m_cnt32 < 65535) m_cnt32++;
                    model_dec(in_inst, 64, d_imm, d_fmt, d_ill);
                    if (d_ill && m_cnt64 < 65535) m_cnt64++;
                end
            end
            m_ready = (q.size() < DEPTH);
        end
    end

    always @(negedge clk) begin : compare
        logic [63:0]      e_imm;
        logic [2:0]       e_fmt;
        logic             e_ill;
        logic [TAG_W-1:0] e_tag;
        bit               ev;
        ev = (q.size() > 0);
        chk("in_ready32", r32, m_ready);
        chk("in_ready64", r64, m_ready);
        chk("out_valid32", v32, ev);
        chk("out_valid64", v64, ev);
        chk("illegal_cnt32", cnt32, m_cnt32);
        chk("illegal_cnt64", cnt64, m_cnt64);
        e_imm = '0; e_fmt = '0; e_ill = 1'b0; e_tag = '0;
        if (ev) begin
            model_dec(q[0][31:0], 32, e_imm, e_fmt, e_ill);
            e_tag = q[0][TAG_W+31:32];
        end
        chk("imm32", imm32, e_imm);
        chk("fmt32", fmt32, e_fmt);
        chk("illegal32", ill32, e_ill);
        chk("tag32", tag32, e_tag);
        if (ev) model_dec(q[0][31:0], 64, e_imm, e_fmt, e_ill);
        chk("imm64", imm64, e_imm);
        chk("fmt64", fmt64, e_fmt);
        chk("illegal64", ill64, e_ill);
        chk("tag64", tag64, e_tag);
    end

    task automatic drive(input bit v, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_inst   = inst;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
    endtask

    logic [31:0] tab [10] = '{32'h00A12303, 32'hFE112E23, 32'h8000006F, 32'h7FFFF0EF,
                              32'h00001517, 32'hFFC50067, 32'h4030D093, 32'h02009093,
                              32'h80000EE3, 32'h7FF00013};

    initial begin
        logic [15:0] c0;
        #12 rst_n = 1'b1;
        #1 chk("lit_ready_before_edge", r32, 1'b0);
        @(posedge clk);
        #1 chk("lit_ready_first_edge", r32, 1'b1);

        drive(1'b1, 32'hFFF00093, 4'h3, 1'b0, 1'b0);
        chk("lit_I_valid", v32, 1'b1);
        chk("lit_I_imm", imm32, 64'hFFFFFFFF);
        chk("lit_I_fmt", fmt32, 3'd1);
        chk("lit_I_tag", tag32, 4'h3);
        pop_one();
        chk("lit_empty_after_pop", v32, 1'b0);

        drive(1'b1, 32'hFE000EE3, 4'h4, 1'b0, 1'b0);
        chk("lit_B_imm", imm32, 64'hFFFFFFFC);
        chk("lit_B_fmt", fmt32, 3'd4);
        pop_one();

        drive(1'b1, 32'h41F0D093, 4'h5, 1'b0, 1'b0);
        chk("lit_srai_imm", imm32, 64'h1F);
        chk("lit_srai_fmt", fmt32, 3'd2);
        chk("lit_srai_ill", ill32, 1'b0);
        pop_one();

        drive(1'b1, 32'h0200D093, 4'h6, 1'b0, 1'b0);
        chk("lit_sh64_imm", imm64, 64'h20);
        chk("lit_sh64_ill", ill64, 1'b0);
        chk("lit_sh32_ill", ill32, 1'b1);
        chk("lit_sh32_imm", imm32, 64'h0);
        chk("lit_sh32_fmt", fmt32, 3'd2);
        pop_one();

        drive(1'b1, 32'h800000B7, 4'h7, 1'b0, 1'b0);
        chk("lit_U64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("lit_U64_fmt", fmt64, 3'd5);
        pop_one();

        c0 = cnt32;
        drive(1'b1, 32'h0000007F, 4'h8, 1'b0, 1'b0);
        chk("lit_bad_ill", ill32, 1'b1);
        chk("lit_bad_fmt", fmt32, 3'd0);
        chk("lit_bad_imm", imm32, 64'h0);
        chk("lit_bad_cnt", cnt32, c0 + 16'd1);
        pop_one();

        // backpressure with a depth-2 buffer
        drive(1'b1, 32'h00100093, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 4'h2, 1'b0, 1'b0);
        chk("lit_full_ready", r32, 1'b0);
        drive(1'b1, 32'h00300093, 4'h3, 1'b0, 1'b0);
        chk("lit_full_head", tag32, 4'h1);
        drive(1'b1, 32'h00300093, 4'h3, 1'b1, 1'b0);
        chk("lit_drain1_head", tag32, 4'h2);
        chk("lit_drain1_ready", r32, 1'b1);
        drive(1'b1, 32'h00300093, 4'h3, 1'b1, 1'b0);
        chk("lit_third_head", tag32, 4'h3);
        pop_one();
        chk("lit_drained", v32, 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tab[i], TAG_W'(i), (i % 3) != 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) pop_one();

        // flush while full, with a concurrent illegal input
        drive(1'b1, 32'h00500013, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 32'h00600013, 4'h6, 1'b0, 1'b0);
        c0 = cnt32;
        drive(1'b1, 32'h0000007F, 4'h7, 1'b1, 1'b1);
        chk("lit_flush_valid", v32, 1'b0);
        chk("lit_flush_ready", r32, 1'b1);
        chk("lit_flush_cnt", cnt32, c0);
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);

        // asynchronous reset in the middle of traffic
        drive(1'b1, 32'hFFF00093, 4'h9, 1'b0, 1'b0);
        drive(1'b1, 32'h0000007F, 4'hA, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_valid", v32, 1'b0);
        chk("lit_rst_imm32", imm32, 64'h0);
        chk("lit_rst_imm64", imm64, 64'h0);
        chk("lit_rst_fmt", fmt32, 3'd0);
        chk("lit_rst_ill", ill32, 1'b0);
        chk("lit_rst_tag", tag32, 4'h0);
        chk("lit_rst_ready", r32, 1'b0);
        chk("lit_rst_cnt", cnt32, 16'h0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // saturation of the illegal counter
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 32'h0000007F, 4'hB, 1'b1, 1'b0);
        end
        chk("lit_sat32", cnt32, 16'hFFFF);
        chk("lit_sat64", cnt64, 16'hFFFF);
        drive(1'b1, 32'h0000007F, 4'hC, 1'b1, 1'b0);
        chk("lit_sat_hold", cnt32, 16'hFFFF);
        for (int i = 0; i < 3; i++) pop_one();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
